// File: rtl/jtkiwi_romrd.sv
// Two-client single-line ROM read cache in front of one SDRAM read port.
// Optional macro JTKIWI_RR_ARB_EN selects round-robin tie breaking instead of scr priority.
module jtkiwi_romrd (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:2] scr_addr,
  input  logic        scr_cs,
  output logic [31:0] scr_data,
  output logic        scr_ok,
  input  logic [19:2] obj_addr,
  input  logic        obj_cs,
  output logic [31:0] obj_data,
  output logic        obj_ok,
  output logic [19:2] rom_addr,
  output logic        rom_req,
  input  logic        rom_ack,
  input  logic        rom_dok,
  input  logic [31:0] rom_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      st;
  state_t      nx;

  logic [19:2] scr_tag;
  logic [19:2] obj_tag;
  logic [31:0] scr_line;
  logic [31:0] obj_line;
  logic        scr_vld;
  logic        obj_vld;
  logic        scr_pend;
  logic        obj_pend;
  logic        gnt;
  logic        pick;
  logic        grant;
  logic        fill;
  logic        scr_miss;
  logic        obj_miss;

  assign scr_ok   = scr_cs & scr_vld & (scr_addr == scr_tag);
  assign obj_ok   = obj_cs & obj_vld & (obj_addr == obj_tag);
  assign scr_data = scr_line;
  assign obj_data = obj_line;
  assign scr_miss = scr_cs & ~scr_ok;
  assign obj_miss = obj_cs & ~obj_ok;

`ifdef JTKIWI_RR_ARB_EN
  // tie pointer: moves only when both clients compete
  logic last;

  assign pick = obj_pend & (~scr_pend | ~last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (grant & scr_pend & obj_pend) begin
      last <= pick;
    end
  end
`else
  assign pick = ~scr_pend;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
    end else begin
      st <= nx;
    end
  end

  always_comb begin
    nx = st;
    unique case (st)
      IDLE: if (scr_pend | obj_pend) nx = REQ;
      REQ:  if (rom_ack) nx = DATA;
      DATA: if (rom_dok) nx = IDLE;
      default: nx = IDLE;
    endcase
  end

  always_comb begin
    rom_req = (st == REQ);
    grant   = (st == IDLE) & (scr_pend | obj_pend);
    fill    = (st == DATA) & rom_dok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= 1'b0;
      rom_addr <= '0;
    end else if (grant) begin
      gnt      <= pick;
      rom_addr <= pick ? obj_addr : scr_addr;
    end
  end

  // a fill clears pending even if the client still misses;
  // a changed address re-pends on the following cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scr_pend <= 1'b0;
      obj_pend <= 1'b0;
    end else begin
      scr_pend <= (fill & ~gnt) ? 1'b0 : (scr_pend | scr_miss);
      obj_pend <= (fill & gnt) ? 1'b0 : (obj_pend | obj_miss);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scr_tag  <= '0;
      scr_line <= '0;
      scr_vld  <= 1'b0;
      obj_tag  <= '0;
      obj_line <= '0;
      obj_vld  <= 1'b0;
    end else if (fill) begin
      if (gnt) begin
        obj_tag  <= rom_addr;
        obj_line <= rom_data;
        obj_vld  <= 1'b1;
      end else begin
        scr_tag  <= rom_addr;
        scr_line <= rom_data;
        scr_vld  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtkiwi_romrd.sv
// Bench for jtkiwi_romrd: plays the SDRAM side and checks against a cache-line model.
// Build with +define+JTKIWI_RR_ARB_EN to check round-robin tie breaking.
module tb_jtkiwi_romrd;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:2] scr_addr;
  logic        scr_cs;
  logic [31:0] scr_data;
  logic        scr_ok;
  logic [19:2] obj_addr;
  logic        obj_cs;
  logic [31:0] obj_data;
  logic        obj_ok;
  logic [19:2] rom_addr;
  logic        rom_req;
  logic        rom_ack;
  logic        rom_dok;
  logic [31:0] rom_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic        m_vld [2];
  logic [17:0] m_tag [2];
  logic [31:0] m_dat [2];
  int          m_ptr;

  jtkiwi_romrd dut (
    .clk      (clk),
    .rst      (rst),
    .scr_addr (scr_addr),
    .scr_cs   (scr_cs),
    .scr_data (scr_data),
    .scr_ok   (scr_ok),
    .obj_addr (obj_addr),
    .obj_cs   (obj_cs),
    .obj_data (obj_data),
    .obj_ok   (obj_ok),
    .rom_addr (rom_addr),
    .rom_req  (rom_req),
    .rom_ack  (rom_ack),
    .rom_dok  (rom_dok),
    .rom_data (rom_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (rom_req) got = 1'b1;
      else cycle();
    end
  endtask

  task automatic pulse_ack();
    rom_ack = 1'b1;
    cycle();
    rom_ack = 1'b0;
  endtask

  task automatic pulse_dok(input logic [31:0] d);
    rom_dok  = 1'b1;
    rom_data = d;
    cycle();
    rom_dok  = 1'b0;
    rom_data = $urandom;
  endtask

  task automatic model_fill(input int c, input logic [17:0] a, input logic [31:0] d);
    m_vld[c] = 1'b1;
    m_tag[c] = a;
    m_dat[c] = d;
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      m_vld[c] = 1'b0;
      m_tag[c] = '0;
      m_dat[c] = '0;
    end
    m_ptr = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    scr_cs = 1'b0; obj_cs = 1'b0;
    scr_addr = '0; obj_addr = '0;
    rom_ack = 1'b0; rom_dok = 1'b0; rom_data = '0;
    idle(3);
    scr_cs = 1'b1; obj_cs = 1'b1;
    #1;
    n_cmp++;
    if ({rom_req, rom_addr} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_rom: req/addr got %b/%h want 0/0", rom_req, rom_addr);
    end
    n_cmp++;
    if ({scr_ok, obj_ok} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_ok: got %b%b want 00", scr_ok, obj_ok);
    end
    n_cmp++;
    if ({scr_data, obj_data} !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_data: got %h %h want 0 0", scr_data, obj_data);
    end
    scr_cs = 1'b0; obj_cs = 1'b0;
    cycle();
    rst = 1'b0;
    model_clear();
    idle(2);
  endtask

  task automatic test_hit();
    bit got;
    scr_addr = 18'h01234;
    scr_cs = 1'b1;
    wait_req(got);
    n_cmp++;
    if (!got || rom_addr !== 18'h01234) begin
      n_bad++;
      $display("FAIL hit_fillreq: got %0d addr %h want 1 01234", got, rom_addr);
    end
    idle(1);
    pulse_ack();
    idle(1);
    pulse_dok(32'hDEADBEEF);
    model_fill(0, 18'h01234, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (scr_ok !== 1'b1 || scr_data !== 32'hDEADBEEF || rom_req !== 1'b0) begin
        n_bad++;
        $display("FAIL hit_hold: ok %b data %h req %b want 1 deadbeef 0",
                 scr_ok, scr_data, rom_req);
      end
      cycle();
    end
    scr_cs = 1'b0;
    #1;
    n_cmp++;
    if (scr_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL hit_csgate: ok %b want 0", scr_ok);
    end
    cycle();
  endtask

  task automatic test_miss();
    bit got;
    scr_addr = 18'h00010;
    scr_cs = 1'b1;
    #1;
    n_cmp++;
    if (scr_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL miss_ok0: ok %b want 0", scr_ok);
    end
    wait_req(got);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL miss_req: got %0d want 1", got);
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (rom_req !== 1'b1 || rom_addr !== 18'h00010) begin
        n_bad++;
        $display("FAIL miss_reqhold: req %b addr %h want 1 00010", rom_req, rom_addr);
      end
      cycle();
    end
    pulse_ack();
    n_cmp++;
    if (rom_req !== 1'b0) begin
      n_bad++;
      $display("FAIL miss_reqdrop: req %b want 0", rom_req);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rom_addr !== 18'h00010 || scr_ok !== 1'b0) begin
        n_bad++;
        $display("FAIL miss_data: addr %h ok %b want 00010 0", rom_addr, scr_ok);
      end
      if (i < 3) cycle();
    end
    pulse_dok(32'h11223344);
    model_fill(0, 18'h00010, 32'h11223344);
    n_cmp++;
    if (scr_ok !== 1'b1 || scr_data !== 32'h11223344) begin
      n_bad++;
      $display("FAIL miss_fill: ok %b data %h want 1 11223344", scr_ok, scr_data);
    end
    scr_cs = 1'b0;
    cycle();
  endtask

  task automatic test_contention(input int k);
    logic [17:0] a [2];
    logic [31:0] d;
    bit          got;
    int          w;
    int          l;
    a[0] = 18'h10000 | 18'(k * 256) | 18'($urandom_range(0, 255));
    a[1] = 18'h30000 | 18'(k * 256) | 18'($urandom_range(0, 255));
`ifdef JTKIWI_RR_ARB_EN
    w = (m_ptr == 1) ? 0 : 1;
    m_ptr = w;
`else
    w = 0;
`endif
    l = 1 - w;
    scr_addr = a[0]; obj_addr = a[1];
    scr_cs = 1'b1; obj_cs = 1'b1;
    #1;
    n_cmp++;
    if ({scr_ok, obj_ok} !== 2'b00) begin
      n_bad++;
      $display("FAIL cont_miss: ok %b%b want 00", scr_ok, obj_ok);
    end
    wait_req(got);
    n_cmp++;
    if (!got || rom_addr !== a[w]) begin
      n_bad++;
      $display("FAIL cont_first: got %0d addr %h want 1 %h", got, rom_addr, a[w]);
    end
    pulse_ack();
    d = $urandom;
    pulse_dok(d);
    model_fill(w, a[w], d);
    n_cmp++;
    if ((w ? obj_ok : scr_ok) !== 1'b1 || (w ? scr_ok : obj_ok) !== 1'b0) begin
      n_bad++;
      $display("FAIL cont_mid: scr_ok %b obj_ok %b winner %0d", scr_ok, obj_ok, w);
    end
    wait_req(got);
    n_cmp++;
    if (!got || rom_addr !== a[l]) begin
      n_bad++;
      $display("FAIL cont_second: got %0d addr %h want 1 %h", got, rom_addr, a[l]);
    end
    pulse_ack();
    d = $urandom;
    pulse_dok(d);
    model_fill(l, a[l], d);
    n_cmp++;
    if (scr_ok !== 1'b1 || obj_ok !== 1'b1 ||
        scr_data !== m_dat[0] || obj_data !== m_dat[1]) begin
      n_bad++;
      $display("FAIL cont_both: ok %b%b data %h %h want 11 %h %h",
               scr_ok, obj_ok, scr_data, obj_data, m_dat[0], m_dat[1]);
    end
    scr_cs = 1'b0; obj_cs = 1'b0;
    cycle();
  endtask

  task automatic test_addr_change();
    logic [31:0] d;
    bit          got;
    obj_addr = 18'h00100;
    obj_cs = 1'b1;
    wait_req(got);
    n_cmp++;
    if (!got || rom_addr !== 18'h00100) begin
      n_bad++;
      $display("FAIL chg_req1: got %0d addr %h want 1 00100", got, rom_addr);
    end
    pulse_ack();
    obj_addr = 18'h00104;
    idle(1);
    n_cmp++;
    if (rom_addr !== 18'h00100) begin
      n_bad++;
      $display("FAIL chg_frozen: addr %h want 00100", rom_addr);
    end
    d = $urandom;
    pulse_dok(d);
    model_fill(1, 18'h00100, d);
    n_cmp++;
    if (obj_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL chg_ok0: ok %b want 0", obj_ok);
    end
    obj_addr = 18'h00100;
    #1;
    n_cmp++;
    if (obj_ok !== 1'b1 || obj_data !== d) begin
      n_bad++;
      $display("FAIL chg_tag: ok %b data %h want 1 %h", obj_ok, obj_data, d);
    end
    obj_addr = 18'h00104;
    #1;
    wait_req(got);
    n_cmp++;
    if (!got || rom_addr !== 18'h00104) begin
      n_bad++;
      $display("FAIL chg_req2: got %0d addr %h want 1 00104", got, rom_addr);
    end
    pulse_ack();
    d = $urandom;
    pulse_dok(d);
    model_fill(1, 18'h00104, d);
    n_cmp++;
    if (obj_ok !== 1'b1 || obj_data !== d) begin
      n_bad++;
      $display("FAIL chg_fill2: ok %b data %h want 1 %h", obj_ok, obj_data, d);
    end
    obj_cs = 1'b0;
    cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bit          got;
    scr_addr = 18'h05550;
    scr_cs = 1'b1;
    wait_req(got);
    pulse_ack();
    idle(1);
    obj_addr = 18'h0AAA8;
    obj_cs = 1'b1;
    d = $urandom;
    pulse_dok(d);
    model_fill(0, 18'h05550, d);
    n_cmp++;
    if (scr_ok !== 1'b1 || rom_req !== 1'b0 || obj_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_fill: scr_ok %b req %b obj_ok %b want 1 0 0",
               scr_ok, rom_req, obj_ok);
    end
    cycle();
    n_cmp++;
    if (rom_req !== 1'b1 || rom_addr !== 18'h0AAA8) begin
      n_bad++;
      $display("FAIL b2b_grant: req %b addr %h want 1 0aaa8", rom_req, rom_addr);
    end
    pulse_ack();
    d = $urandom;
    pulse_dok(d);
    model_fill(1, 18'h0AAA8, d);
    n_cmp++;
    if (obj_ok !== 1'b1 || obj_data !== d || scr_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_obj: obj_ok %b data %h scr_ok %b want 1 %h 1",
               obj_ok, obj_data, scr_ok, d);
    end
    scr_cs = 1'b0; obj_cs = 1'b0;
    cycle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bit          got;
    scr_addr = 18'h07770;
    scr_cs = 1'b1;
    wait_req(got);
    pulse_ack();
    idle(1);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (rom_req !== 1'b0 || scr_ok !== 1'b0 || obj_ok !== 1'b0 ||
        scr_data !== 32'd0 || obj_data !== 32'd0) begin
      n_bad++;
      $display("FAIL rstmid_clear: req %b ok %b%b data %h %h want 0 00 0 0",
               rom_req, scr_ok, obj_ok, scr_data, obj_data);
    end
    cycle();
    rst = 1'b0;
    model_clear();
    rom_dok = 1'b1;
    rom_data = 32'hBAD0BAD0;
    cycle();
    rom_dok = 1'b0;
    n_cmp++;
    if (scr_ok !== 1'b0 || scr_data !== 32'd0) begin
      n_bad++;
      $display("FAIL rstmid_stray: ok %b data %h want 0 0", scr_ok, scr_data);
    end
    wait_req(got);
    n_cmp++;
    if (!got || rom_addr !== 18'h07770) begin
      n_bad++;
      $display("FAIL rstmid_rereq: got %0d addr %h want 1 07770", got, rom_addr);
    end
    pulse_ack();
    d = $urandom;
    pulse_dok(d);
    model_fill(0, 18'h07770, d);
    n_cmp++;
    if (scr_ok !== 1'b1 || scr_data !== d) begin
      n_bad++;
      $display("FAIL rstmid_fill: ok %b data %h want 1 %h", scr_ok, scr_data, d);
    end
    scr_cs = 1'b0;
    cycle();
  endtask

  task automatic test_stray();
    rom_ack = 1'b1;
    rom_dok = 1'b1;
    rom_data = $urandom;
    cycle();
    rom_ack = 1'b0;
    rom_dok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rom_req !== 1'b0 || scr_ok !== 1'b0 || obj_ok !== 1'b0) begin
        n_bad++;
        $display("FAIL stray_idle: req %b ok %b%b want 0 00", rom_req, scr_ok, obj_ok);
      end
      cycle();
    end
    scr_addr = m_tag[0];
    scr_cs = 1'b1;
    #1;
    n_cmp++;
    if (scr_ok !== m_vld[0] || scr_data !== m_dat[0]) begin
      n_bad++;
      $display("FAIL stray_line: ok %b data %h want %b %h",
               scr_ok, scr_data, m_vld[0], m_dat[0]);
    end
    scr_cs = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    logic [17:0] pool [4];
    logic [17:0] a;
    logic [31:0] d;
    logic        okv;
    logic [31:0] dv;
    logic        exp_hit;
    bit          got;
    int          c;
    pool[0] = 18'h00000;
    pool[1] = 18'h3FFFF;
    pool[2] = 18'h02000;
    pool[3] = 18'h02004;
    for (int it = 0; it < 40; it++) begin
      c = $urandom_range(0, 1);
      a = pool[$urandom_range(0, 3)];
      if (c == 0) begin
        scr_addr = a; scr_cs = 1'b1;
      end else begin
        obj_addr = a; obj_cs = 1'b1;
      end
      #1;
      exp_hit = m_vld[c] && (m_tag[c] == a);
      okv = c ? obj_ok : scr_ok;
      dv = c ? obj_data : scr_data;
      n_cmp++;
      if (okv !== exp_hit || (exp_hit && dv !== m_dat[c])) begin
        n_bad++;
        $display("FAIL rnd_look: client %0d addr %h ok %b data %h want %b %h",
                 c, a, okv, dv, exp_hit, m_dat[c]);
      end
      if (!exp_hit) begin
        wait_req(got);
        n_cmp++;
        if (!got || rom_addr !== a) begin
          n_bad++;
          $display("FAIL rnd_req: got %0d addr %h want 1 %h", got, rom_addr, a);
        end
        idle($urandom_range(0, 3));
        pulse_ack();
        idle($urandom_range(0, 3));
        d = $urandom;
        pulse_dok(d);
        model_fill(c, a, d);
        okv = c ? obj_ok : scr_ok;
        dv = c ? obj_data : scr_data;
        n_cmp++;
        if (okv !== 1'b1 || dv !== d) begin
          n_bad++;
          $display("FAIL rnd_fill: client %0d ok %b data %h want 1 %h", c, okv, dv, d);
        end
      end else begin
        cycle();
        n_cmp++;
        if (rom_req !== 1'b0) begin
          n_bad++;
          $display("FAIL rnd_hitreq: req %b want 0", rom_req);
        end
      end
      scr_cs = 1'b0; obj_cs = 1'b0;
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_contention(1);
    test_contention(2);
    test_addr_change();
    test_back_to_back();
    test_reset_mid();
    test_stray();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
